traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Phase sequencer for a two-road intersection: main road north-south (NS), side road east-west (EW) with a vehicle sensor. A Moore state machine with a 5-bit down-counter produces the light outputs and the remaining-time count for each phase. It also drives the select line of the 5-bit `mux21` that routes per-road 5-bit data onto the shared output: `I1` carries NS data, `I2` carries EW data.

## Interface
Parameters:
- `GREEN_NS_T`, default 20: minimum NS green, in ticks (legal range 1..31)
- `GREEN_EW_T`, default 15: EW green, in ticks (1..31)
- `YELLOW_T`, default 3: yellow for either road, in ticks (1..31)
- `RED_T`, default 1: all-red clearance, in ticks (1..31)

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `tick`  in  1  time-base enable; each cycle with `tick`=1 counts as one tick
- `ew_req`  in  1  EW vehicle sensor, level; sampled every cycle
- `ns_light`  out  3  {R,Y,G} one-hot, registered
- `ew_light`  out  3  {R,Y,G} one-hot, registered
- `sel`  out  1  drives `mux21` S; 0 selects NS data, 1 selects EW data
- `cnt`  out  5  ticks remaining in the current phase
- `phase`  out  3  current state encoding, for debug and display

## Operation
- States, in cycle order:
  - NS_GREEN: ns=G, ew=R
  - NS_YELLOW: ns=Y, ew=R
  - RED_A: both R
  - EW_GREEN: ns=R, ew=G
  - EW_YELLOW: ns=R, ew=Y
  - RED_B: both R
  - RED_B returns to NS_GREEN.
- Phase entry: `cnt` loads the phase duration parameter.
- Tick with `cnt` > 1: `cnt` decrements.
- Tick with `cnt` == 1: the FSM advances and `cnt` loads the next phase's duration. Every phase except NS_GREEN therefore lasts exactly its parameter in ticks.
- NS_GREEN holds the road for traffic:
  - Tick with `cnt` == 1 and no pending request: `cnt` goes to 0 and the state stays NS_GREEN.
  - Tick with `cnt` == 0 and a pending request: the FSM advances to NS_YELLOW.
  - Tick with `cnt` == 1 and a pending request: the FSM advances directly to NS_YELLOW.
  - `cnt` never underflows; at 0 it holds 0.
- Request latch `req_pend`:
  - Set when `ew_req`=1 in any state except EW_GREEN.
  - Cleared on the transition into EW_GREEN. This clear overrides a set in the same cycle.
  - A request arriving during EW_YELLOW or RED_B is kept and triggers the next EW cycle.
- `sel` is 1 in EW_GREEN, EW_YELLOW and RED_B, and 0 otherwise. It is registered together with the state.
- `tick`=0: all state and count values hold. `ew_req` is still latched.
- `tick` held high is legal; each such cycle is one tick.
- Reset values:
  - state NS_GREEN, `phase`=0
  - `cnt`=GREEN_NS_T, `req_pend`=0
  - `ns_light`=001, `ew_light`=100
  - `sel`=0
- Reset mid-operation: `rst` overrides `tick` and `ew_req`. The reset values appear after the next rising edge, in any state.
- Safety invariant: `ns_light` and `ew_light` are never non-red at the same time, and each is always one-hot.

## Timing
- All outputs are registered. `ns_light`, `ew_light`, `sel`, `phase` and `cnt` change on the same edge as the state.
- Latency:
  - `tick` to `cnt` or state change: 1 cycle.
  - `ew_req` to `req_pend`: 1 cycle. A request seen on the same cycle as the advancing tick in NS_GREEN does not advance the FSM on that tick.
- Full EW service from NS_GREEN at `cnt`=0 with `req_pend` set is YELLOW_T + RED_T + GREEN_EW_T + YELLOW_T + RED_T ticks. With defaults that is 23 ticks.

## Structure
- Package `traffic_pkg`:
  - phase encodings: NS_GREEN=0, NS_YELLOW=1, RED_A=2, EW_GREEN=3, EW_YELLOW=4, RED_B=5
  - light constants: RED=3'b100, YEL=3'b010, GRN=3'b001
  - 5-bit count width constant
- Sub-module `phase_timer`:
  - 5-bit loadable down-counter, saturating at 0
  - inputs: `clk`, `rst`, `load`, `load_val`, `en`
  - outputs: `cnt`, `last` (`last` = `cnt`==1)
- `traffic_phase_ctrl` contains the FSM, the request latch and the output registers. It instantiates one `phase_timer`.

## Test plan
- Reset, then 25 ticks with `ew_req`=0:
  - `cnt` counts 20→1 and then holds 0.
  - State stays NS_GREEN; `ns_light`=001, `sel`=0.
- 1-cycle `ew_req` pulse while `cnt`=0 in NS_GREEN:
  - Next tick: NS_YELLOW, `cnt`=3.
  - 3 ticks later: RED_A, `cnt`=1.
  - 1 tick later: EW_GREEN, `cnt`=15, `sel`=1, `req_pend`=0.
- `ew_req` held high throughout:
  - No request is latched during EW_GREEN.
  - After RED_B the FSM returns to NS_GREEN with `cnt`=20 and `req_pend`=1.
  - After 20 ticks NS_YELLOW follows immediately.
- `tick` low for 50 cycles mid-EW_GREEN at `cnt`=7: `cnt`, state and lights are unchanged.
- `rst` asserted in EW_YELLOW on the same cycle as `tick`:
  - Next edge: NS_GREEN, `cnt`=20, `sel`=0, `req_pend`=0.
- Random `tick`/`ew_req` for 10k cycles:
  - Both lights never non-red together.
  - Both lights always one-hot.
  - `sel` matches the EW-owned states.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase sequencer: phase codes, light patterns, count width.
package traffic_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5
    } phase_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    function automatic logic [2:0] ns_light_of(input phase_e p);
        case (p)
            NS_GREEN:  return GRN;
            NS_YELLOW: return YEL;
            default:   return RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_light_of(input phase_e p);
        case (p)
            EW_GREEN:  return GRN;
            EW_YELLOW: return YEL;
            default:   return RED;
        endcase
    endfunction

    // The EW road owns the shared data path from its green through its clearance.
    function automatic logic ew_owned(input phase_e p);
        return (p == EW_GREEN) || (p == EW_YELLOW) || (p == RED_B);
    endfunction

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return RED_A;
            RED_A:     return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return RED_B;
            default:   return NS_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at 0; load wins over decrement.
// One-cycle latency from load/en to cnt; no backpressure.
module phase_timer
    import traffic_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= RST_VAL;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road phase sequencer: NS holds green until an EW request is latched, then one EW cycle runs.
// All outputs registered, one cycle after tick; no backpressure, tick=0 freezes timing.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_NS_T = 20,
    parameter int unsigned GREEN_EW_T = 15,
    parameter int unsigned YELLOW_T   = 3,
    parameter int unsigned RED_T      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ew_req,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             sel,
    output logic [CNT_W-1:0] cnt,
    output logic [2:0]       phase
);

    function automatic logic [CNT_W-1:0] dur_of(input phase_e p);
        case (p)
            NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW_T);
            RED_A, RED_B:         return CNT_W'(RED_T);
            EW_GREEN:             return CNT_W'(GREEN_EW_T);
            default:              return CNT_W'(GREEN_NS_T);
        endcase
    endfunction

    phase_e           r_state;
    logic             r_req_pend;
    logic [2:0]       r_ns_light;
    logic [2:0]       r_ew_light;
    logic             r_sel;

    logic [CNT_W-1:0] w_cnt;
    logic             w_last;
    logic             w_zero;
    logic             w_adv;
    phase_e           w_nxt_state;

    assign w_zero = (w_cnt == '0);

    // NS green may sit at 0 indefinitely; every other phase leaves on its last tick.
    always_comb begin
        w_adv = 1'b0;
        if (tick) begin
            if (r_state == NS_GREEN) begin
                w_adv = r_req_pend && (w_last || w_zero);
            end else begin
                w_adv = w_last || w_zero;
            end
        end
        w_nxt_state = w_adv ? next_phase(r_state) : r_state;
    end

    phase_timer #(
        .RST_VAL (CNT_W'(GREEN_NS_T))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_adv),
        .load_val (dur_of(w_nxt_state)),
        .en       (tick),
        .cnt      (w_cnt),
        .last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= NS_GREEN;
            r_req_pend <= 1'b0;
            r_ns_light <= GRN;
            r_ew_light <= RED;
            r_sel      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_ns_light <= ns_light_of(w_nxt_state);
            r_ew_light <= ew_light_of(w_nxt_state);
            r_sel      <= ew_owned(w_nxt_state);
            // Entering EW green consumes the request, even if one is seen that same cycle.
            if (w_adv && (w_nxt_state == EW_GREEN)) begin
                r_req_pend <= 1'b0;
            end else if (ew_req && (r_state != EW_GREEN)) begin
                r_req_pend <= 1'b1;
            end
        end
    end

    assign ns_light = r_ns_light;
    assign ew_light = r_ew_light;
    assign sel      = r_sel;
    assign cnt      = w_cnt;
    assign phase    = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench: directed steps queue hand-computed expectations tagged by edge number;
// a monitor checks them plus the light/sel invariants after every rising edge.
module tb_traffic_phase_ctrl;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       ew_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       sel;
    logic [4:0] cnt;
    logic [2:0] phase;

    traffic_phase_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ew_req   (ew_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .sel      (sel),
        .cnt      (cnt),
        .phase    (phase)
    );

    typedef struct {
        int          edge_no;
        logic [2:0]  ph;
        logic [4:0]  cnt;
        logic [2:0]  ns;
        logic [2:0]  ew;
        logic        sel;
        logic [63:0] name;
    } exp_t;

    exp_t q[$];
    int   n_edges = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   tgt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        n_edges++;
        n_checks++;
        if ($onehot(ns_light) && $onehot(ew_light) &&
            !((ns_light != 3'b100) && (ew_light != 3'b100)) &&
            (sel == ((phase == 3'd3) || (phase == 3'd4) || (phase == 3'd5)))) begin
            n_pass++;
        end else begin
            $display("FAIL invariant @edge %0d: ns=%b ew=%b sel=%b phase=%0d, want one-hot, no conflict, sel=EW-owned",
                     n_edges, ns_light, ew_light, sel, phase);
        end
        while (q.size() > 0 && q[0].edge_no <= n_edges) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (e.edge_no == n_edges && phase == e.ph && cnt == e.cnt &&
                ns_light == e.ns && ew_light == e.ew && sel == e.sel) begin
                n_pass++;
            end else begin
                $display("FAIL %s @edge %0d: phase/cnt/ns/ew/sel got %0d/%0d/%b/%b/%b want %0d/%0d/%b/%b/%b (for edge %0d)",
                         e.name, n_edges, phase, cnt, ns_light, ew_light, sel,
                         e.ph, e.cnt, e.ns, e.ew, e.sel, e.edge_no);
            end
        end
    end

    task automatic step(input logic t, input logic r, input logic rs);
        @(negedge clk);
        tick   = t;
        ew_req = r;
        rst    = rs;
        tgt    = n_edges + 1;
    endtask

    task automatic expect_st(input logic [63:0] nm, input logic [2:0] ph, input logic [4:0] c);
        exp_t e;
        e.edge_no = tgt;
        e.ph      = ph;
        e.cnt     = c;
        e.name    = nm;
        case (ph)
            3'd0:    begin e.ns = 3'b001; e.ew = 3'b100; e.sel = 1'b0; end
            3'd1:    begin e.ns = 3'b010; e.ew = 3'b100; e.sel = 1'b0; end
            3'd2:    begin e.ns = 3'b100; e.ew = 3'b100; e.sel = 1'b0; end
            3'd3:    begin e.ns = 3'b100; e.ew = 3'b001; e.sel = 1'b1; end
            3'd4:    begin e.ns = 3'b100; e.ew = 3'b010; e.sel = 1'b1; end
            default: begin e.ns = 3'b100; e.ew = 3'b100; e.sel = 1'b1; end
        endcase
        q.push_back(e);
    endtask

    task automatic tick_chk(input logic r, input logic [63:0] nm, input logic [2:0] ph, input logic [4:0] c);
        step(1'b1, r, 1'b0);
        expect_st(nm, ph, c);
    endtask

    task automatic count_down(input logic r, input logic [63:0] nm, input logic [2:0] ph, input int from, input int n);
        for (int i = 1; i <= n; i++) begin
            tick_chk(r, nm, ph, (from - i > 0) ? 5'(from - i) : 5'd0);
        end
    endtask

    // Runs from NS_YELLOW with cnt=3 through one EW service back to NS_GREEN with cnt=20.
    task automatic service(input logic r_pre, input logic r_grn, input logic r_post);
        tick_chk(r_pre, "ns_yel", 3'd1, 5'd2);
        tick_chk(r_pre, "ns_yel", 3'd1, 5'd1);
        tick_chk(r_pre, "red_a", 3'd2, 5'd1);
        tick_chk(r_pre, "ew_grn", 3'd3, 5'd15);
        count_down(r_grn, "ew_grn", 3'd3, 15, 14);
        tick_chk(r_grn, "ew_yel", 3'd4, 5'd3);
        tick_chk(r_post, "ew_yel", 3'd4, 5'd2);
        tick_chk(r_post, "ew_yel", 3'd4, 5'd1);
        tick_chk(r_post, "red_b", 3'd5, 5'd1);
        tick_chk(r_post, "ns_ret", 3'd0, 5'd20);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; ew_req = 1'b0;

        step(1'b0, 1'b0, 1'b1); expect_st("reset", 3'd0, 5'd20);
        step(1'b1, 1'b1, 1'b1); expect_st("reset2", 3'd0, 5'd20);

        count_down(1'b0, "ns_idle", 3'd0, 20, 25);

        step(1'b0, 1'b1, 1'b0); expect_st("req_hold", 3'd0, 5'd0);
        tick_chk(1'b0, "go_yel", 3'd1, 5'd3);
        service(1'b0, 1'b0, 1'b0);
        count_down(1'b0, "no_pend", 3'd0, 20, 21);

        tick_chk(1'b1, "req_lat", 3'd0, 5'd0);
        tick_chk(1'b1, "go_yel", 3'd1, 5'd3);
        service(1'b1, 1'b1, 1'b1);
        count_down(1'b1, "pend", 3'd0, 20, 19);
        tick_chk(1'b1, "pend_yel", 3'd1, 5'd3);

        tick_chk(1'b0, "ns_yel", 3'd1, 5'd2);
        tick_chk(1'b0, "ns_yel", 3'd1, 5'd1);
        tick_chk(1'b0, "red_a", 3'd2, 5'd1);
        tick_chk(1'b0, "ew_grn", 3'd3, 5'd15);
        count_down(1'b1, "grn_req", 3'd3, 15, 8);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1, 1'b0); expect_st("freeze", 3'd3, 5'd7);
        end
        count_down(1'b0, "ew_grn", 3'd3, 7, 6);
        tick_chk(1'b0, "ew_yel", 3'd4, 5'd3);
        tick_chk(1'b0, "ew_yel", 3'd4, 5'd2);
        tick_chk(1'b0, "ew_yel", 3'd4, 5'd1);
        tick_chk(1'b0, "red_b", 3'd5, 5'd1);
        tick_chk(1'b0, "ns_ret", 3'd0, 5'd20);
        count_down(1'b0, "no_latch", 3'd0, 20, 21);

        tick_chk(1'b1, "req_lat", 3'd0, 5'd0);
        tick_chk(1'b0, "go_yel", 3'd1, 5'd3);
        tick_chk(1'b0, "ns_yel", 3'd1, 5'd2);
        tick_chk(1'b0, "ns_yel", 3'd1, 5'd1);
        tick_chk(1'b0, "red_a", 3'd2, 5'd1);
        tick_chk(1'b0, "ew_grn", 3'd3, 5'd15);
        count_down(1'b0, "ew_grn", 3'd3, 15, 14);
        tick_chk(1'b0, "ew_yel", 3'd4, 5'd3);
        step(1'b1, 1'b1, 1'b1); expect_st("rst_mid", 3'd0, 5'd20);
        count_down(1'b0, "post_rst", 3'd0, 20, 21);

        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want stimulus finished");
        $fatal(1, "watchdog expired");
    end

endmodule
